// File: rtl/rtmc_pkg.sv
// Shared types and defaults for the RTMC SPI-to-register-bus bridge.
// Opcodes and response codes match the byte values the host sends and receives.
package rtmc_pkg;

    localparam int RTMC_ADDR_W      = 8;
    localparam int RTMC_DATA_W      = 16;
    localparam int RTMC_BUS_TIMEOUT = 255;

    typedef enum logic [7:0] {
        O_NOP = 8'h00,
        O_RD  = 8'h01,
        O_WR  = 8'h02
    } op_t;

    typedef enum logic [7:0] {
        R_BUSY     = 8'h00,
        R_ACK      = 8'h01,
        R_ACK_DATA = 8'h02
    } result_t;

    typedef enum logic [2:0] {
        B_IDLE,
        B_ADDR,
        B_DHI,
        B_DLO,
        B_EXEC,
        B_RESP
    } bridge_state_t;

    function automatic logic is_bus_op(input logic [7:0] b);
        return (b == O_RD) || (b == O_WR);
    endfunction

endpackage

// File: rtl/rtmc_spi_bridge.sv
// Frame decoder between an SPI byte shifter and a register bus: op/addr/data bytes in,
// one bus read or write per frame, result and read-data bytes out via host polling.
module rtmc_spi_bridge
    import rtmc_pkg::*;
#(
    parameter int ADDR_W      = RTMC_ADDR_W,
    parameter int DATA_W      = RTMC_DATA_W,
    parameter int BUS_TIMEOUT = RTMC_BUS_TIMEOUT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cs_active,
    input  logic              rx_valid,
    input  logic [7:0]        rx_byte,
    output logic [7:0]        tx_byte,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    output logic              bus_we,
    output logic              bus_re,
    input  logic [DATA_W-1:0] bus_rdata,
    input  logic              bus_ready,
    output logic              busy,
    output logic              err
);

    localparam int TMO_W = 16;
    localparam logic [TMO_W-1:0] TMO_LAST =
        (BUS_TIMEOUT > 0) ? TMO_W'(BUS_TIMEOUT - 1) : '0;

    bridge_state_t     state_q;
    logic [7:0]        tx_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic              we_q;
    logic              re_q;
    logic              err_q;
    logic              is_wr_q;
    logic [1:0]        idx_q;
    logic [TMO_W-1:0]  tmo_q;
    logic              cs_lost_q;

    logic rx_take;
    logic tmo_hit;

    assign rx_take = rx_valid && cs_active;
    assign tmo_hit = (BUS_TIMEOUT != 0) && (tmo_q == TMO_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= B_IDLE;
            tx_q      <= 8'h00;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            we_q      <= 1'b0;
            re_q      <= 1'b0;
            err_q     <= 1'b0;
            is_wr_q   <= 1'b0;
            idx_q     <= 2'd0;
            tmo_q     <= '0;
            cs_lost_q <= 1'b0;
        end else begin
            err_q <= 1'b0;
            case (state_q)
                B_IDLE: begin
                    tx_q <= 8'h00;
                    if (rx_take) begin
                        if (is_bus_op(rx_byte)) begin
                            is_wr_q <= (rx_byte == O_WR);
                            state_q <= B_ADDR;
                        end else if (rx_byte != O_NOP) begin
                            err_q <= 1'b1;
                        end
                    end
                end

                B_ADDR: begin
                    if (!cs_active) begin
                        state_q <= B_IDLE;
                        tx_q    <= 8'h00;
                    end else if (rx_valid) begin
                        addr_q <= ADDR_W'(rx_byte);
                        if (is_wr_q) begin
                            state_q <= B_DHI;
                        end else begin
                            state_q   <= B_EXEC;
                            re_q      <= 1'b1;
                            tmo_q     <= '0;
                            cs_lost_q <= 1'b0;
                        end
                    end
                end

                B_DHI: begin
                    if (!cs_active) begin
                        state_q <= B_IDLE;
                        tx_q    <= 8'h00;
                    end else if (rx_valid) begin
                        wdata_q[DATA_W-1:DATA_W-8] <= rx_byte;
                        state_q <= B_DLO;
                    end
                end

                B_DLO: begin
                    if (!cs_active) begin
                        state_q <= B_IDLE;
                        tx_q    <= 8'h00;
                    end else if (rx_valid) begin
                        wdata_q[7:0] <= rx_byte;
                        state_q      <= B_EXEC;
                        we_q         <= 1'b1;
                        tmo_q        <= '0;
                        cs_lost_q    <= 1'b0;
                    end
                end

                // Polls are absorbed here; a deselect only defers the return to idle
                // so an issued write always reaches the bus.
                B_EXEC: begin
                    tx_q <= R_BUSY;
                    if (!cs_active) begin
                        cs_lost_q <= 1'b1;
                    end
                    if (bus_ready) begin
                        we_q <= 1'b0;
                        re_q <= 1'b0;
                        if (!is_wr_q) begin
                            rdata_q <= bus_rdata;
                        end
                        if (cs_lost_q || !cs_active) begin
                            state_q <= B_IDLE;
                            tx_q    <= 8'h00;
                        end else begin
                            state_q <= B_RESP;
                            tx_q    <= is_wr_q ? R_ACK : R_ACK_DATA;
                            idx_q   <= 2'd0;
                        end
                    end else if (tmo_hit) begin
                        we_q    <= 1'b0;
                        re_q    <= 1'b0;
                        err_q   <= 1'b1;
                        state_q <= B_IDLE;
                        tx_q    <= 8'h00;
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                    end
                end

                B_RESP: begin
                    if (!cs_active) begin
                        state_q <= B_IDLE;
                        tx_q    <= 8'h00;
                    end else if (rx_valid) begin
                        if (is_wr_q || idx_q == 2'd2) begin
                            state_q <= B_IDLE;
                            tx_q    <= 8'h00;
                        end else if (idx_q == 2'd0) begin
                            tx_q  <= rdata_q[DATA_W-1:DATA_W-8];
                            idx_q <= 2'd1;
                        end else begin
                            tx_q  <= rdata_q[7:0];
                            idx_q <= 2'd2;
                        end
                    end
                end

                default: begin
                    state_q <= B_IDLE;
                    tx_q    <= 8'h00;
                    we_q    <= 1'b0;
                    re_q    <= 1'b0;
                end
            endcase
        end
    end

    assign tx_byte   = tx_q;
    assign bus_addr  = addr_q;
    assign bus_wdata = wdata_q;
    assign bus_we    = we_q;
    assign bus_re    = re_q;
    assign busy      = (state_q != B_IDLE);
    assign err       = err_q;

endmodule

// File: tb/tb_rtmc_spi_bridge.sv
// Directed bench for rtmc_spi_bridge: frames, polling, errors, deselects, timeout and reset.
module tb_rtmc_spi_bridge;

    logic        clk;
    logic        rst;
    logic        cs_active;
    logic        rx_valid;
    logic [7:0]  rx_byte;
    logic [7:0]  tx_byte;
    logic [7:0]  bus_addr;
    logic [15:0] bus_wdata;
    logic        bus_we;
    logic        bus_re;
    logic [15:0] bus_rdata;
    logic        bus_ready;
    logic        busy;
    logic        err;

    // second instance with a short bus timeout
    logic        t_cs_active;
    logic        t_rx_valid;
    logic [7:0]  t_rx_byte;
    logic [7:0]  t_tx_byte;
    logic [7:0]  t_bus_addr;
    logic [15:0] t_bus_wdata;
    logic        t_bus_we;
    logic        t_bus_re;
    logic [15:0] t_bus_rdata;
    logic        t_bus_ready;
    logic        t_busy;
    logic        t_err;

    int checks = 0;
    int errors = 0;
    int we_rise = 0;
    int re_rise = 0;
    int err_cnt = 0;
    int t_err_cnt = 0;
    logic we_prev = 1'b0;
    logic re_prev = 1'b0;

    rtmc_spi_bridge dut (
        .clk       (clk),
        .rst       (rst),
        .cs_active (cs_active),
        .rx_valid  (rx_valid),
        .rx_byte   (rx_byte),
        .tx_byte   (tx_byte),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_we    (bus_we),
        .bus_re    (bus_re),
        .bus_rdata (bus_rdata),
        .bus_ready (bus_ready),
        .busy      (busy),
        .err       (err)
    );

    rtmc_spi_bridge #(.BUS_TIMEOUT(4)) dut_tmo (
        .clk       (clk),
        .rst       (rst),
        .cs_active (t_cs_active),
        .rx_valid  (t_rx_valid),
        .rx_byte   (t_rx_byte),
        .tx_byte   (t_tx_byte),
        .bus_addr  (t_bus_addr),
        .bus_wdata (t_bus_wdata),
        .bus_we    (t_bus_we),
        .bus_re    (t_bus_re),
        .bus_rdata (t_bus_rdata),
        .bus_ready (t_bus_ready),
        .busy      (t_busy),
        .err       (t_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        we_prev <= bus_we;
        re_prev <= bus_re;
        if (bus_we && !we_prev) we_rise <= we_rise + 1;
        if (bus_re && !re_prev) re_rise <= re_rise + 1;
        if (err) err_cnt <= err_cnt + 1;
        if (t_err) t_err_cnt <= t_err_cnt + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_byte  = b;
        tick();
        rx_valid = 1'b0;
        tick();
    endtask

    task automatic send_t(input logic [7:0] b);
        t_rx_valid = 1'b1;
        t_rx_byte  = b;
        tick();
        t_rx_valid = 1'b0;
        tick();
    endtask

    initial begin
        rst = 1'b1;
        cs_active = 1'b0; rx_valid = 1'b0; rx_byte = 8'h00;
        bus_rdata = 16'h0000; bus_ready = 1'b0;
        t_cs_active = 1'b0; t_rx_valid = 1'b0; t_rx_byte = 8'h00;
        t_bus_rdata = 16'h0000; t_bus_ready = 1'b0;
        tick(); tick();
        rst = 1'b0;
        tick();

        // reset state
        chk("rst_tx", tx_byte, 8'h00);
        chk("rst_we", bus_we, 1'b0);
        chk("rst_re", bus_re, 1'b0);
        chk("rst_addr", bus_addr, 8'h00);
        chk("rst_wdata", bus_wdata, 16'h0000);
        chk("rst_busy", busy, 1'b0);
        chk("rst_err", err, 1'b0);

        // 1: write frame 02 06 12 34
        cs_active = 1'b1;
        send(8'h02);
        chk("wr_busy_op", busy, 1'b1);
        chk("wr_tx_op", tx_byte, 8'h00);
        send(8'h06);
        chk("wr_addr", bus_addr, 8'h06);
        send(8'h12);
        chk("wr_we_early", bus_we, 1'b0);
        send(8'h34);
        chk("wr_we", bus_we, 1'b1);
        chk("wr_wdata", bus_wdata, 16'h1234);
        chk("wr_tx_exec", tx_byte, 8'h00);
        send(8'h00);
        chk("wr_tx_poll", tx_byte, 8'h00);
        chk("wr_we_held", bus_we, 1'b1);
        bus_ready = 1'b1;
        tick();
        bus_ready = 1'b0;
        chk("wr_we_drop", bus_we, 1'b0);
        chk("wr_tx_ack", tx_byte, 8'h01);
        send(8'h00);
        chk("wr_tx_idle", tx_byte, 8'h00);
        chk("wr_busy_end", busy, 1'b0);
        chk("wr_we_pulses", we_rise, 1);

        // 2: read frame 01 05, rdata BEEF
        send(8'h01);
        send(8'h05);
        chk("rd_re", bus_re, 1'b1);
        chk("rd_we", bus_we, 1'b0);
        chk("rd_addr", bus_addr, 8'h05);
        tick();
        chk("rd_re_held", bus_re, 1'b1);
        bus_rdata = 16'hBEEF;
        bus_ready = 1'b1;
        tick();
        bus_ready = 1'b0;
        bus_rdata = 16'h0000;
        chk("rd_re_drop", bus_re, 1'b0);
        chk("rd_tx_ackd", tx_byte, 8'h02);
        send(8'h00);
        chk("rd_tx_hi", tx_byte, 8'hBE);
        send(8'h00);
        chk("rd_tx_lo", tx_byte, 8'hEF);
        send(8'h00);
        chk("rd_tx_end", tx_byte, 8'h00);
        chk("rd_busy_end", busy, 1'b0);
        chk("rd_re_pulses", re_rise, 1);

        // 3: illegal opcode, then a good read
        send(8'h7F);
        chk("bad_err_cnt", err_cnt, 1);
        chk("bad_busy", busy, 1'b0);
        chk("bad_we_pulses", we_rise, 1);
        chk("bad_re_pulses", re_rise, 1);
        send(8'h01);
        send(8'h09);
        chk("bad_rd_addr", bus_addr, 8'h09);
        bus_rdata = 16'h1357;
        bus_ready = 1'b1;
        tick();
        bus_ready = 1'b0;
        bus_rdata = 16'h0000;
        chk("bad_rd_ackd", tx_byte, 8'h02);
        send(8'h00);
        chk("bad_rd_hi", tx_byte, 8'h13);
        send(8'h00);
        chk("bad_rd_lo", tx_byte, 8'h57);
        send(8'h00);
        chk("bad_rd_end", busy, 1'b0);

        // 4a: deselect after the data-high byte
        send(8'h02);
        send(8'h20);
        send(8'h55);
        cs_active = 1'b0;
        tick();
        chk("cs_busy", busy, 1'b0);
        chk("cs_tx", tx_byte, 8'h00);
        cs_active = 1'b1;
        tick();
        send(8'h00);
        chk("cs_still_idle", busy, 1'b0);
        chk("cs_no_we", we_rise, 1);

        // 4b: deselect during a write in EXEC
        send(8'h02);
        send(8'h21);
        send(8'hAB);
        send(8'hCD);
        chk("csx_we", bus_we, 1'b1);
        cs_active = 1'b0;
        tick(); tick();
        chk("csx_we_held", bus_we, 1'b1);
        chk("csx_busy", busy, 1'b1);
        bus_ready = 1'b1;
        tick();
        bus_ready = 1'b0;
        chk("csx_we_drop", bus_we, 1'b0);
        chk("csx_idle", busy, 1'b0);
        chk("csx_tx", tx_byte, 8'h00);
        chk("csx_addr", bus_addr, 8'h21);
        chk("csx_wdata", bus_wdata, 16'hABCD);
        chk("csx_we_pulses", we_rise, 2);
        cs_active = 1'b1;
        tick();

        // 5: bus timeout of 4 cycles on the second instance
        t_cs_active = 1'b1;
        send_t(8'h01);
        send_t(8'h33);
        chk("tmo_re", t_bus_re, 1'b1);
        tick(); tick();
        chk("tmo_re_held", t_bus_re, 1'b1);
        chk("tmo_err_early", t_err, 1'b0);
        tick();
        chk("tmo_re_drop", t_bus_re, 1'b0);
        chk("tmo_err", t_err, 1'b1);
        chk("tmo_busy", t_busy, 1'b0);
        chk("tmo_tx", t_tx_byte, 8'h00);
        tick();
        chk("tmo_err_pulse", t_err, 1'b0);
        t_bus_rdata = 16'h5A5A;
        t_bus_ready = 1'b1;
        tick();
        t_bus_ready = 1'b0;
        tick();
        chk("tmo_late_busy", t_busy, 1'b0);
        chk("tmo_late_tx", t_tx_byte, 8'h00);
        chk("tmo_err_cnt", t_err_cnt, 1);

        // 6: poll byte coincident with ready in read EXEC
        send(8'h01);
        send(8'h44);
        rx_valid  = 1'b1;
        rx_byte   = 8'h00;
        bus_rdata = 16'hCAFE;
        bus_ready = 1'b1;
        tick();
        rx_valid  = 1'b0;
        bus_ready = 1'b0;
        bus_rdata = 16'h0000;
        chk("co_tx_ackd", tx_byte, 8'h02);
        chk("co_re_drop", bus_re, 1'b0);
        tick();
        send(8'h00);
        chk("co_tx_hi", tx_byte, 8'hCA);
        send(8'h00);
        chk("co_tx_lo", tx_byte, 8'hFE);
        send(8'h00);
        chk("co_tx_end", tx_byte, 8'h00);
        chk("co_re_pulses", re_rise, 3);

        // reset in the middle of a write EXEC
        send(8'h02);
        send(8'h10);
        send(8'h11);
        send(8'h22);
        chk("mr_we", bus_we, 1'b1);
        rst = 1'b1;
        tick();
        chk("mr_we_rst", bus_we, 1'b0);
        chk("mr_re_rst", bus_re, 1'b0);
        chk("mr_tx_rst", tx_byte, 8'h00);
        chk("mr_addr_rst", bus_addr, 8'h00);
        chk("mr_wdata_rst", bus_wdata, 16'h0000);
        chk("mr_busy_rst", busy, 1'b0);
        chk("mr_err_rst", err, 1'b0);
        rst = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
